letter_sequencer: RTL and testbench

//  Upstream stage of the 7-segment letter decoder: records a short message of 6-bit letter codes from SW[5:0]
//  on pushbutton presses, then replays it one letter per display tick. LETTER_CODE drives the decoder's
//  6-bit input directly. LEDG reports fill count, mode and full status.

---
 rtl/letter_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 36 +++
 rtl/letter_sequencer.sv | 147 ++++++++++++++
 tb/tb_letter_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/letter_pkg.sv
// Shared letter encoding and sequencer state type for the 7-segment letter path.
// Contents: CODE_W, BLANK and letter constants (same encoding as the decoder),
//           state_e {ST_REC, ST_PLAY}.
package letter_pkg;

    localparam int unsigned CODE_W = 6;

    localparam logic [CODE_W-1:0] BLANK  = 6'b000000;
    localparam logic [CODE_W-1:0] CODE_A = 6'b100000;
    localparam logic [CODE_W-1:0] CODE_B = 6'b101000;
    localparam logic [CODE_W-1:0] CODE_C = 6'b110000;
    localparam logic [CODE_W-1:0] CODE_Z = 6'b100111;

    typedef enum logic [0:0] {
        ST_REC  = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchronizer with falling-edge pulse detector.
// Ports: clk, rst_n       clock, async active-low reset
//        d[WIDTH]         asynchronous input
//        q[WIDTH]         synchronized level (last synchronizer stage)
//        fall_c[WIDTH]    1-cycle pulse when q goes 1 -> 0 (combinational from flops)
module sync_edge_det #(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned WIDTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] fall_c
);

    // STAGES must be >= 2; stage 0 captures the raw input
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{{WIDTH{RST_VAL}}}};
            prev_q <= {WIDTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q      = sync_q[STAGES-1];
    assign fall_c = prev_q & ~q;

endmodule

// File: rtl/letter_sequencer.sv
// Records a short message of letter codes on key presses, then replays it one
// letter per display tick to the 7-segment letter decoder.
// Ports: CLOCK_50           system clock
//        RESET_N            async active-low reset
//        SW[9:0]            [5:0] letter code, [8] clear, [9] mode (0=REC, 1=PLAY)
//        KEY_ADD_N          active-low pushbutton, press appends SW[5:0]
//        LETTER_CODE[CODE_W] registered code to decoder
//        LEDG[7:0]          [4:0] count, [5] tick, [6] PLAY, [7] FULL
module letter_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CODE_W   = 6
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [9:0]        SW,
    input  logic              KEY_ADD_N,
    output logic [CODE_W-1:0] LETTER_CODE,
    output logic [7:0]        LEDG
);

    import letter_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RD_W  = $clog2(DEPTH);
    localparam int unsigned PS_W  = $clog2(TICK_DIV);

    logic [9:0]        sw_s;
    logic [9:0]        sw_fall_unused;
    logic              key_q_unused;
    logic              add_pulse_c;
    logic              unused_bits;

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [RD_W-1:0]   rd_ptr, rd_ptr_nxt;
    logic [PS_W-1:0]   ps, ps_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [7:0]        ledg_nxt;
    logic              tick_c;
    logic              wr_en_c;

    logic [CODE_W-1:0] mem [DEPTH];

    // Switch synchronizer (level only)
    sync_edge_det #(.STAGES(2), .WIDTH(10), .RST_VAL(1'b0)) u_sw_sync (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .d      (SW),
        .q      (sw_s),
        .fall_c (sw_fall_unused)
    );

    // Key synchronizer; idles high so reset release never looks like a press
    sync_edge_det #(.STAGES(2), .WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .d      (KEY_ADD_N),
        .q      (key_q_unused),
        .fall_c (add_pulse_c)
    );

    assign unused_bits = ^{sw_s[7:6], sw_fall_unused, key_q_unused};

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        ps_nxt     = ps;
        code_nxt   = LETTER_CODE;
        tick_c     = 1'b0;
        wr_en_c    = 1'b0;

        case (state)
            ST_REC: begin
                code_nxt = CODE_W'(sw_s[5:0]);
                // Level clear wins over a press in the same cycle
                if (sw_s[8]) begin
                    count_nxt = '0;
                end else if (add_pulse_c && (count < CNT_W'(DEPTH))) begin
                    wr_en_c   = 1'b1;
                    count_nxt = count + CNT_W'(1);
                end
                if (sw_s[9]) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (count == '0) begin
                    code_nxt = CODE_W'(BLANK);
                end else begin
                    code_nxt = mem[rd_ptr];
                    if (ps == PS_W'(TICK_DIV - 1)) begin
                        tick_c     = 1'b1;
                        ps_nxt     = '0;
                        rd_ptr_nxt = (CNT_W'(rd_ptr) == (count - CNT_W'(1))) ? '0
                                                                             : rd_ptr + RD_W'(1);
                    end else begin
                        ps_nxt = ps + PS_W'(1);
                    end
                end
                if (!sw_s[9]) begin
                    state_nxt = ST_REC;
                end
            end
            default: begin
                state_nxt = ST_REC;
            end
        endcase

        // Every state entry restarts playback from the first letter
        if (state_nxt != state) begin
            rd_ptr_nxt = '0;
            ps_nxt     = '0;
        end

        ledg_nxt = {(count_nxt == CNT_W'(DEPTH)), (state_nxt == ST_PLAY), tick_c, 5'(count_nxt)};
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_REC;
            count       <= '0;
            rd_ptr      <= '0;
            ps          <= '0;
            LETTER_CODE <= CODE_W'(BLANK);
            LEDG        <= 8'h00;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            rd_ptr      <= rd_ptr_nxt;
            ps          <= ps_nxt;
            LETTER_CODE <= code_nxt;
            LEDG        <= ledg_nxt;
        end
    end

    // Message store; contents are don't-care above count, so no reset
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_c) begin
            mem[RD_W'(count)] <= CODE_W'(sw_s[5:0]);
        end
    end

endmodule

// File: tb/tb_letter_sequencer.sv
// Self-checking bench for letter_sequencer with DEPTH=4, TICK_DIV=4.
module tb_letter_sequencer;

    localparam logic [5:0] L_A = 6'b100000;
    localparam logic [5:0] L_B = 6'b101000;
    localparam logic [5:0] L_C = 6'b110000;
    localparam logic [5:0] L_Z = 6'b100111;
    localparam logic [5:0] L_X = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic       key;
    logic [5:0] code;
    logic [7:0] ledg;

    int vectors;
    int miscompares;

    typedef struct {
        logic [9:0] sw;
        logic       key;
        int         cyc;
        logic [5:0] code;
        logic [7:0] ledg;
    } vec_t;

    vec_t vt[$];

    letter_sequencer #(.DEPTH(4), .TICK_DIV(4), .CODE_W(6)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .SW          (sw),
        .KEY_ADD_N   (key),
        .LETTER_CODE (code),
        .LEDG        (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [9:0] s, input logic k, input int c,
                           input logic [5:0] ec, input logic [7:0] el);
        vec_t v;
        v.sw = s; v.key = k; v.cyc = c; v.code = ec; v.ledg = el;
        vt.push_back(v);
    endtask

    task automatic press(input logic [5:0] c);
        sw  = {4'b0000, c};
        key = 1'b0;
        repeat (10) @(negedge clk);
        key = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [5:0] exp_mem [4];
        logic       tk;

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        sw    = 10'h000;
        key   = 1'b1;

        // Record preview, three presses, play, clear handling, empty play
        add_vec(10'h000, 1'b1, 3, 6'h00, 8'h00);
        add_vec({4'h0, L_A}, 1'b1, 2, 6'h00, 8'h00);
        add_vec({4'h0, L_A}, 1'b1, 1, L_A, 8'h00);
        add_vec({4'h0, L_A}, 1'b0, 2, L_A, 8'h00);
        add_vec({4'h0, L_A}, 1'b0, 1, L_A, 8'h01);
        add_vec({4'h0, L_A}, 1'b0, 7, L_A, 8'h01);
        add_vec({4'h0, L_B}, 1'b1, 4, L_B, 8'h01);
        add_vec({4'h0, L_B}, 1'b0, 3, L_B, 8'h02);
        add_vec({4'h0, L_B}, 1'b0, 7, L_B, 8'h02);
        add_vec({4'h0, L_C}, 1'b1, 4, L_C, 8'h02);
        add_vec({4'h0, L_C}, 1'b0, 3, L_C, 8'h03);
        add_vec({4'h0, L_C}, 1'b0, 7, L_C, 8'h03);
        add_vec({4'h0, L_C}, 1'b1, 4, L_C, 8'h03);
        add_vec(10'h200, 1'b1, 3, 6'h00, 8'h43);
        add_vec(10'h200, 1'b1, 1, L_A, 8'h43);
        add_vec(10'h200, 1'b1, 3, L_A, 8'h63);
        add_vec(10'h200, 1'b1, 1, L_B, 8'h43);
        add_vec(10'h200, 1'b1, 3, L_B, 8'h63);
        add_vec(10'h200, 1'b1, 1, L_C, 8'h43);
        add_vec(10'h200, 1'b1, 3, L_C, 8'h63);
        add_vec(10'h200, 1'b1, 1, L_A, 8'h43);
        add_vec(10'h300, 1'b0, 4, L_B, 8'h43);
        add_vec(10'h300, 1'b1, 3, L_B, 8'h63);
        add_vec(10'h300, 1'b1, 1, L_C, 8'h43);
        add_vec(10'h000, 1'b1, 4, 6'h00, 8'h03);
        add_vec(10'h121, 1'b0, 3, 6'h21, 8'h00);
        add_vec(10'h121, 1'b0, 7, 6'h21, 8'h00);
        add_vec(10'h021, 1'b1, 4, 6'h21, 8'h00);
        add_vec(10'h221, 1'b1, 3, 6'h21, 8'h40);
        add_vec(10'h221, 1'b1, 1, 6'h00, 8'h40);
        add_vec(10'h221, 1'b1, 8, 6'h00, 8'h40);
        add_vec(10'h000, 1'b1, 4, 6'h00, 8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset code", {2'b00, code}, 8'h00);
        chk("reset ledg", ledg, 8'h00);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            sw  = vt[i].sw;
            key = vt[i].key;
            repeat (vt[i].cyc) @(negedge clk);
            chk($sformatf("v%0d code", i), {2'b00, code}, {2'b00, vt[i].code});
            chk($sformatf("v%0d ledg", i), ledg, vt[i].ledg);
        end

        // Fill to capacity; fifth press ignored
        exp_mem[0] = L_A; exp_mem[1] = L_B; exp_mem[2] = L_C; exp_mem[3] = L_Z;
        for (int i = 0; i < 4; i++) begin
            press(exp_mem[i]);
            chk($sformatf("fill%0d ledg", i), ledg, (i == 3) ? 8'h84 : 8'(i + 1));
            chk($sformatf("fill%0d code", i), {2'b00, code}, {2'b00, exp_mem[i]});
        end
        press(L_X);
        chk("full extra ledg", ledg, 8'h84);

        // Play four letters and wrap
        sw = 10'h200;
        repeat (3) @(negedge clk);
        for (int k = 4; k < 24; k++) begin
            @(negedge clk);
            tk = (((k - 4) % 4) == 3);
            chk($sformatf("full play k%0d code", k), {2'b00, code}, {2'b00, exp_mem[((k - 4) / 4) % 4]});
            chk($sformatf("full play k%0d ledg", k), ledg, {2'b11, tk, 5'd4});
        end

        // Async reset mid-PLAY
        sw = 10'h000;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset code", {2'b00, code}, 8'h00);
        chk("async reset ledg", ledg, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post reset code", {2'b00, code}, 8'h00);
        chk("post reset ledg", ledg, 8'h00);
        sw = 10'h200;
        repeat (5) @(negedge clk);
        chk("lost msg code", {2'b00, code}, 8'h00);
        chk("lost msg ledg", ledg, 8'h40);
        sw = 10'h000;
        repeat (4) @(negedge clk);

        // Single-letter message: pointer stays on entry 0
        press(L_A);
        chk("one ledg", ledg, 8'h01);
        sw = 10'h200;
        repeat (3) @(negedge clk);
        for (int k = 4; k < 12; k++) begin
            @(negedge clk);
            tk = (((k - 4) % 4) == 3);
            chk($sformatf("one play k%0d code", k), {2'b00, code}, {2'b00, L_A});
            chk($sformatf("one play k%0d ledg", k), ledg, {2'b01, tk, 5'd1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
